// File: rtl/riscv_mem_pkg.sv
// Shared constants for the data-memory path: access-size encodings, default bus widths
// and the state encoding of the data-memory port arbiter.
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // funct3 encodings of RV32I loads and stores, as understood by data_mem
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic {
    ARB_CPU   = 1'b0,
    ARB_FORCE = 1'b1
  } arbState_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of cycles the host has been kept waiting behind the CPU.
// hit flags the last tolerated wait cycle, so the arbiter can force a stall on the next one.
module arb_wait_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cntReg;
  logic [CNT_W-1:0] cntNext;

  always_comb begin
    cntNext = cntReg;
    if (clr) begin
      cntNext = '0;
    end else if (inc && (cntReg != CNT_MAX)) begin
      cntNext = cntReg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cntReg <= '0;
    end else begin
      cntReg <= cntNext;
    end
  end

  assign hit = (cntReg == CNT_HIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data_mem port between the CPU load/store path and a host port.
// The CPU owns the bus whenever it asks; the host gets idle slots plus a one-cycle forced stall after a long wait.
module dmem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_funct3,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [2:0]        host_funct3,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  arbState_t stateReg;
  arbState_t stateNext;
  logic      waitInc;
  logic      waitHit;
  logic      handshake;

  arb_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) waitCounter (
    .clk  (clk),
    .reset(reset),
    .clr  (!waitInc),
    .inc  (waitInc),
    .hit  (waitHit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg <= ARB_CPU;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = ARB_CPU;
    if ((stateReg == ARB_CPU) && cpu_req && host_valid && waitHit) begin
      stateNext = ARB_FORCE;
    end
  end

  // Grant is decided by cpu_req and state only; host_* merely steers the already-granted slot.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_funct3 = cpu_funct3;
    host_ready = 1'b0;
    cpu_stall  = 1'b0;
    waitInc    = 1'b0;
    if (!reset) begin
      mem_we     = host_valid && host_we;
      mem_addr   = host_addr;
      mem_wdata  = host_wdata;
      mem_funct3 = host_funct3;
      host_ready = host_valid;
    end else begin
      case (stateReg)
        ARB_CPU: begin
          if (cpu_req) begin
            mem_we  = cpu_we;
            waitInc = host_valid;
          end else if (host_valid) begin
            mem_we     = host_we;
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
            mem_funct3 = host_funct3;
            host_ready = 1'b1;
          end
        end
        ARB_FORCE: begin
          cpu_stall  = 1'b1;
          mem_we     = host_valid && host_we;
          mem_addr   = host_addr;
          mem_wdata  = host_wdata;
          mem_funct3 = host_funct3;
          host_ready = 1'b1;
        end
        default: begin
          mem_we = 1'b0;
        end
      endcase
    end
  end

  assign handshake = host_valid && host_ready;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= handshake;
      if (handshake) begin
        rsp_data <= host_we ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-addressed data_mem model attached.
module tb_dmem_port_arbiter;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [2:0]  host_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] memArray [0:63];

  always #5 clk = ~clk;

  assign mem_rdata = memArray[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) memArray[mem_addr[7:2]] <= mem_wdata;
  end

  dmem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_WAIT(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_funct3 (cpu_funct3),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_funct3(host_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nextCyc();
    @(negedge clk);
  endtask

  task automatic setHost(input logic valid, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    host_valid  = valid;
    host_we     = we;
    host_addr   = addr;
    host_wdata  = wdata;
    host_funct3 = we ? FUNCT3_SW : FUNCT3_LW;
    if (valid) $display("txn host %s addr=%h wdata=%h", we ? "wr" : "rd", addr, wdata);
  endtask

  // Cycles in which the CPU holds the bus and the host must keep waiting.
  task automatic holdCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i > 0) nextCyc();
      #1;
      chk({tag, "_ready"}, 32'(host_ready), 32'd0);
      chk({tag, "_stall"}, 32'(cpu_stall), 32'd0);
      chk({tag, "_addr"}, mem_addr, cpu_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) memArray[i] = 32'h0;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_funct3 = FUNCT3_LW;
    setHost(1'b0, 1'b0, 32'h0, 32'h0);

    nextCyc(); nextCyc(); #1;
    chk("rst_ready", 32'(host_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_rspd", rsp_data, 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);

    // Load four words while held in reset
    for (int i = 0; i < 4; i++) begin
      nextCyc();
      setHost(1'b1, 1'b1, 32'(i * 4), 32'hA0 + 32'(i));
      #1;
      chk("load_ready", 32'(host_ready), 32'd1);
      chk("load_we", 32'(mem_we), 32'd1);
      chk("load_addr", mem_addr, 32'(i * 4));
      chk("load_rspv", 32'(rsp_valid), 32'd0);
    end
    nextCyc(); setHost(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("load_rspv_end", 32'(rsp_valid), 32'd0);
    nextCyc(); reset = 1'b1; #1;
    chk("rel_stall", 32'(cpu_stall), 32'd0);
    chk("rel_rspv", 32'(rsp_valid), 32'd0);

    // Host path while the CPU is idle, back-to-back handshakes
    nextCyc(); setHost(1'b1, 1'b1, 32'h10, 32'hDEADBEEF); #1;
    chk("idle_wr_ready", 32'(host_ready), 32'd1);
    chk("idle_wr_we", 32'(mem_we), 32'd1);
    nextCyc(); setHost(1'b1, 1'b0, 32'h10, 32'h0); #1;
    chk("idle_wr_rspv", 32'(rsp_valid), 32'd1);
    chk("idle_wr_rspd", rsp_data, 32'h0);
    chk("idle_rd_ready", 32'(host_ready), 32'd1);
    chk("idle_rd_we", 32'(mem_we), 32'd0);
    nextCyc(); setHost(1'b1, 1'b1, 32'h20, 32'h20202020); #1;
    chk("idle_rd_rspv", 32'(rsp_valid), 32'd1);
    chk("idle_rd_rspd", rsp_data, 32'hDEADBEEF);
    nextCyc(); setHost(1'b1, 1'b1, 32'h24, 32'h24242424);
    nextCyc(); setHost(1'b1, 1'b0, 32'h8, 32'h0);
    nextCyc(); setHost(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("load_readback", rsp_data, 32'hA2);
    nextCyc(); #1;
    chk("idle_rspv_drop", 32'(rsp_valid), 32'd0);

    // Contention: eight waits, forced slot, and the store in that slot is suppressed
    nextCyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_wdata = 32'h0;
    setHost(1'b1, 1'b0, 32'h24, 32'h0);
    holdCycles(8, "cont1");
    nextCyc(); cpu_we = 1'b1; cpu_wdata = 32'hBADBAD00; #1;
    chk("force_stall", 32'(cpu_stall), 32'd1);
    chk("force_ready", 32'(host_ready), 32'd1);
    chk("force_we", 32'(mem_we), 32'd0);
    chk("force_addr", mem_addr, 32'h24);
    nextCyc(); cpu_we = 1'b0; cpu_wdata = 32'h0; #1;
    chk("after_force_rspv", 32'(rsp_valid), 32'd1);
    chk("after_force_rspd", rsp_data, 32'h24242424);
    holdCycles(1, "cont2a");
    nextCyc(); holdCycles(7, "cont2b");
    nextCyc(); #1;
    chk("period_stall", 32'(cpu_stall), 32'd1);
    chk("period_ready", 32'(host_ready), 32'd1);
    nextCyc(); cpu_req = 1'b0; setHost(1'b1, 1'b0, 32'h20, 32'h0); #1;
    chk("post_ready", 32'(host_ready), 32'd1);
    chk("post_stall", 32'(cpu_stall), 32'd0);
    nextCyc(); setHost(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("store_inhibit", rsp_data, 32'h20202020);

    // Host withdraws after five waits; the count starts over on reassertion
    nextCyc(); cpu_req = 1'b1; setHost(1'b1, 1'b0, 32'h24, 32'h0);
    holdCycles(5, "wd1");
    nextCyc(); setHost(1'b0, 1'b0, 32'h24, 32'h0); #1;
    chk("wd_drop_ready", 32'(host_ready), 32'd0);
    nextCyc(); setHost(1'b1, 1'b0, 32'h24, 32'h0);
    holdCycles(8, "wd2");
    nextCyc(); #1;
    chk("wd_stall", 32'(cpu_stall), 32'd1);
    nextCyc(); setHost(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("wd_rspv", 32'(rsp_valid), 32'd1);
    chk("wd_stall_end", 32'(cpu_stall), 32'd0);

    // Reset asserted in the forced cycle
    nextCyc(); setHost(1'b1, 1'b0, 32'h24, 32'h0);
    holdCycles(8, "mr1");
    nextCyc(); reset = 1'b0; #1;
    chk("mr_rst_stall", 32'(cpu_stall), 32'd0);
    chk("mr_rst_ready", 32'(host_ready), 32'd1);
    nextCyc(); reset = 1'b1; setHost(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("mr_stall", 32'(cpu_stall), 32'd0);
    chk("mr_rspv", 32'(rsp_valid), 32'd0);
    nextCyc(); setHost(1'b1, 1'b0, 32'h24, 32'h0);
    holdCycles(8, "mr2");
    nextCyc(); #1;
    chk("mr_fresh_stall", 32'(cpu_stall), 32'd1);
    nextCyc(); cpu_req = 1'b0; setHost(1'b0, 1'b0, 32'h0, 32'h0);
    nextCyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
